linear_interpolator: RTL

LINEAR_INTERPOLATOR -- requirements
Module: linear_interpolator

---
 rtl/linear_interpolator.sv | 137 +++++++++++++
 1 files changed

// File: rtl/linear_interpolator.sv
// linear_interpolator: upsamples an unsigned sample stream by R = 2^LOG2_RATIO.
// Each accepted sample C is preceded by the previous sample P.
// The block emits R outputs P + ((k*(C-P)) >>> LOG2_RATIO) for k = 1..R.
// Build macro LINEAR_INTERP_ROUND_EN: adds 2^(LOG2_RATIO-1) before the shift
// (round half up); otherwise the shift floors.
module linear_interpolator #(
    parameter int DATA_WIDTH = 8,
    parameter int LOG2_RATIO = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready
);
    localparam int DIFF_W = DATA_WIDTH + LOG2_RATIO + 2;
    localparam int K_W    = LOG2_RATIO + 1;
    localparam logic [K_W-1:0] RATIO = K_W'(1 << LOG2_RATIO);
    localparam logic [K_W-1:0] K_ONE = K_W'(1);
`ifdef LINEAR_INTERP_ROUND_EN
    localparam logic signed [DIFF_W-1:0] ROUND_TERM = DIFF_W'(1 << (LOG2_RATIO - 1));
`else
    localparam logic signed [DIFF_W-1:0] ROUND_TERM = '0;
`endif

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [DATA_WIDTH-1:0]   p_q, p_d, c_q, c_d;
    logic [DATA_WIDTH-1:0]   pend_q, pend_d;
    logic                    pend_vld_q, pend_vld_d;
    logic                    o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;
    logic                    up_xfer, dn_xfer, load;
    logic [DATA_WIDTH-1:0]   load_data;

    // The result always lies between p and c, so the low DATA_WIDTH bits are exact.
    function automatic logic [DATA_WIDTH-1:0] interp(
        input logic [DATA_WIDTH-1:0] p,
        input logic [DATA_WIDTH-1:0] c,
        input logic [K_W-1:0]        k
    );
        logic signed [DIFF_W-1:0] diff;
        logic signed [DIFF_W-1:0] prod;
        logic signed [DIFF_W-1:0] sum;
        diff = $signed(DIFF_W'(c)) - $signed(DIFF_W'(p));
        prod = (diff * $signed(DIFF_W'(k))) + ROUND_TERM;
        sum  = $signed(DIFF_W'(p)) + (prod >>> LOG2_RATIO);
        return sum[DATA_WIDTH-1:0];
    endfunction

    // Ready depends on state only. It is held low while reset is asserted.
    // A sample arriving at k=R during a downstream stall is parked in pend_q.
    assign o_ready = !i_reset && ((state_q == IDLE) || ((k_q == RATIO) && !pend_vld_q));
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;

    // Next-state: load a new P/C pair, step k, or fall back to IDLE.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        p_d        = p_q;
        c_d        = c_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        o_valid_d  = o_valid_q;
        o_data_d   = o_data_q;
        up_xfer    = i_valid && o_ready;
        dn_xfer    = o_valid_q && i_ready;
        load       = 1'b0;
        load_data  = i_data;
        case (state_q)
            IDLE: begin
                if (up_xfer) load = 1'b1;
            end
            RUN: begin
                if (dn_xfer) begin
                    if (k_q == RATIO) begin
                        if (up_xfer) begin
                            load = 1'b1;
                        end else if (pend_vld_q) begin
                            load       = 1'b1;
                            load_data  = pend_q;
                            pend_vld_d = 1'b0;
                        end else begin
                            state_d   = IDLE;
                            o_valid_d = 1'b0;
                            k_d       = '0;
                        end
                    end else begin
                        k_d      = k_q + K_ONE;
                        o_data_d = interp(p_q, c_q, k_q + K_ONE);
                    end
                end else if (up_xfer) begin
                    pend_d     = i_data;
                    pend_vld_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            p_d       = c_q;
            c_d       = load_data;
            k_d       = K_ONE;
            state_d   = RUN;
            o_valid_d = 1'b1;
            o_data_d  = interp(c_q, load_data, K_ONE);
        end
    end

    // State, sample history and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            p_q        <= '0;
            c_q        <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            p_q        <= p_d;
            c_q        <= c_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
        end
    end
endmodule
